// File: rtl/uart_case_pkg.sv
// -----------------------------------------------------------------------------
// uart_case_pkg
// Shared definitions for the uart case-converter stream stage:
//   - case mode encodings
//   - output FSM state encoding
//   - ASCII letter range constants and the upper/lower case offset
//   - case_convert(): combinational byte conversion for a given mode
// -----------------------------------------------------------------------------
package uart_case_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_UPPER  = 2'b01,
        MODE_LOWER  = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_UC_FIRST = 8'h41;
    localparam logic [7:0] ASCII_UC_LAST  = 8'h5A;
    localparam logic [7:0] ASCII_LC_FIRST = 8'h61;
    localparam logic [7:0] ASCII_LC_LAST  = 8'h7A;
    localparam logic [7:0] CASE_OFFSET    = 8'h20;

    // Only the two ASCII letter ranges are ever modified; every other code,
    // including 0x80..0xFF, is returned unchanged in all modes.
    function automatic logic [7:0] case_convert(input logic [7:0] b,
                                                input logic [1:0] m);
        logic       w_is_uc;
        logic       w_is_lc;
        logic [7:0] w_res;
        w_is_uc = (b >= ASCII_UC_FIRST) && (b <= ASCII_UC_LAST);
        w_is_lc = (b >= ASCII_LC_FIRST) && (b <= ASCII_LC_LAST);
        w_res   = b;
        case (m)
            MODE_PASS: begin
                w_res = b;
            end
            MODE_UPPER: begin
                if (w_is_lc) w_res = b - CASE_OFFSET;
                else         w_res = b;
            end
            MODE_LOWER: begin
                if (w_is_uc) w_res = b + CASE_OFFSET;
                else         w_res = b;
            end
            MODE_TOGGLE: begin
                if (w_is_uc)      w_res = b + CASE_OFFSET;
                else if (w_is_lc) w_res = b - CASE_OFFSET;
                else              w_res = b;
            end
            default: begin
                w_res = b;
            end
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/uart_case_stream_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous FIFO with read/write pointers wrapping at DEPTH (power of two)
// and a registered occupancy level. Reusable by other uart-side blocks.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push, i_wdata  write request and data (ignored when full without pop)
//   i_pop          read request (ignored when empty); o_rdata is head entry
//   i_flush        synchronous clear, priority over push and pop
//   o_level, o_full, o_empty  registered occupancy and flags
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             r_empty;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !i_flush && !r_empty;
    assign w_do_push = i_push && !i_flush && (!r_full || w_do_pop);

    // Next occupancy; flush wins over any push/pop activity.
    always_comb begin
        w_level_nxt = r_level;
        if (i_flush) begin
            w_level_nxt = '0;
        end else if (w_do_push && !w_do_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_level_nxt = r_level - LVL_W'(1);
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Pointers, level and flags; flags come from the next level so they are registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Storage array; contents need no reset because the level gates reads.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_case_stream.sv
// -----------------------------------------------------------------------------
// uart_case_stream
// Byte-stream stage between uart_rx and uart_tx: converts each received byte
// with the run-time case mode, queues it in a byte_fifo and feeds uart_tx
// through an IDLE/LOAD/START/WAIT_BUSY/WAIT_DONE handshake FSM.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   mode                  00 pass, 01 upper, 10 lower, 11 toggle
//   flush                 synchronous FIFO clear pulse
//   rx_valid, rx_data     received byte strobe and data
//   tx_ready              uart_tx idle indication
//   tx_start, tx_data     one-cycle start pulse and held byte to uart_tx
//   fifo_level/full/empty FIFO occupancy
//   overflow_cnt          saturating count of bytes dropped on a full FIFO
//   byte_cnt              saturating count of bytes handed to uart_tx
// -----------------------------------------------------------------------------
module uart_case_stream
    import uart_case_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             flush,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             tx_ready,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [LVL_W-1:0] fifo_level,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] overflow_cnt,
    output logic [CNT_W-1:0] byte_cnt
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic [CNT_W-1:0] r_overflow_cnt;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [7:0]       w_conv;
    logic [7:0]       w_fifo_rdata;
    logic [LVL_W-1:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Mode is sampled together with the byte, so queued bytes never change.
    assign w_conv = case_convert(rx_data, mode);

    // Full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign w_push = rx_valid && !flush && (!w_full || w_pop);
    assign w_drop = rx_valid && !flush && w_full && !w_pop;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .LVL_W (LVL_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata (w_conv),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_rdata (w_fifo_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output FSM next-state and pop decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && tx_ready && !flush) w_state_nxt = ST_LOAD;
                else                                w_state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                // A flush arriving here clears the head before it is loaded,
                // so nothing is sent.
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_START;
                    w_pop       = 1'b1;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) w_state_nxt = ST_WAIT_DONE;
                else           w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_DONE: begin
                if (tx_ready) w_state_nxt = ST_IDLE;
                else          w_state_nxt = ST_WAIT_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Registered tx interface: start pulse is high exactly while in START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= (w_state_nxt == ST_START);
            if (w_pop) r_tx_data <= w_fifo_rdata;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow_cnt <= '0;
            r_byte_cnt     <= '0;
        end else begin
            if (w_drop && (r_overflow_cnt != {CNT_W{1'b1}}))
                r_overflow_cnt <= r_overflow_cnt + CNT_W'(1);
            if ((r_state == ST_START) && (r_byte_cnt != {CNT_W{1'b1}}))
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    assign tx_start     = r_tx_start;
    assign tx_data      = r_tx_data;
    assign fifo_level   = w_level;
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign overflow_cnt = r_overflow_cnt;
    assign byte_cnt     = r_byte_cnt;

endmodule

// File: tb/tb_uart_case_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_case_stream
// Directed stimulus with hand-computed expected bytes pushed into a scoreboard
// queue; a monitor pops and compares on every tx_start. A small uart_tx model
// drops tx_ready for FRAME cycles after each start pulse.
// -----------------------------------------------------------------------------
module tb_uart_case_stream;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int LVL_W = 5;
    localparam int FRAME = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic             flush;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             tx_ready;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] overflow_cnt;
    logic [CNT_W-1:0] byte_cnt;

    int          total;
    int          bad;
    int          n_start;
    int          busy;
    bit          hold_tx;
    logic [7:0]  sb [$];

    uart_case_stream #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .flush        (flush),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_ready     (tx_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .fifo_level   (fifo_level),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow_cnt (overflow_cnt),
        .byte_cnt     (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx model: busy for FRAME cycles after each start pulse.
    initial begin
        tx_ready = 1'b1;
        busy     = 0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && !rst) busy = FRAME;
            if (busy > 0) begin
                tx_ready = 1'b0;
                busy--;
            end else begin
                tx_ready = !hold_tx;
            end
        end
    end

    // Monitor: every start pulse must match the next expected byte.
    initial begin
        n_start = 0;
        forever begin
            @(negedge clk);
            if (!rst && tx_start === 1'b1) begin
                n_start++;
                if (sb.size() == 0) begin
                    chk("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_data", {24'h0, tx_data}, {24'h0, sb.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit exp_v, input logic [7:0] e);
        rx_data  = b;
        rx_valid = 1'b1;
        if (exp_v) sb.push_back(e);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (FRAME + 6) @(negedge clk);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total    = 0;
        bad      = 0;
        hold_tx  = 1'b0;
        rst      = 1'b1;
        mode     = 2'b00;
        flush    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_level", {27'h0, fifo_level}, 32'h0);
        chk("rst_empty", {31'h0, fifo_empty}, 32'h1);
        chk("rst_full", {31'h0, fifo_full}, 32'h0);
        chk("rst_ovf", {16'h0, overflow_cnt}, 32'h0);
        chk("rst_bcnt", {16'h0, byte_cnt}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Upper mode: "aZ{"
        mode = 2'b01;
        send(8'h61, 1'b1, 8'h41);
        send(8'h5A, 1'b1, 8'h5A);
        send(8'h7B, 1'b1, 8'h7B);
        drain();
        chk("upper_bcnt", {16'h0, byte_cnt}, 32'd3);
        chk("upper_starts", n_start, 32'd3);

        // Toggle mode, then switch to lower with two bytes still queued
        mode = 2'b11;
        send(8'h41, 1'b1, 8'h61);
        send(8'h62, 1'b1, 8'h42);
        send(8'hE1, 1'b1, 8'hE1);
        chk("toggle_queued", {27'h0, fifo_level}, 32'd2);
        mode = 2'b10;
        send(8'h51, 1'b1, 8'h71);
        send(8'h7A, 1'b1, 8'h7A);
        drain();
        chk("lower_bcnt", {16'h0, byte_cnt}, 32'd8);

        // Overflow: tx held busy, 20 bytes into a 16-entry FIFO
        mode    = 2'b00;
        hold_tx = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            send(8'h30 + 8'(i), (i < 16), 8'h30 + 8'(i));
        end
        chk("ovf_full", {31'h0, fifo_full}, 32'h1);
        chk("ovf_level", {27'h0, fifo_level}, 32'd16);
        chk("ovf_cnt", {16'h0, overflow_cnt}, 32'd4);

        // Release tx; push exactly in the LOAD (pop) cycle while full
        #1 hold_tx = 1'b0;
        @(negedge clk);          // model raises tx_ready, IDLE -> LOAD next edge
        @(negedge clk);          // now in LOAD
        send(8'hC5, 1'b1, 8'hC5);
        chk("popfull_level", {27'h0, fifo_level}, 32'd16);
        chk("popfull_full", {31'h0, fifo_full}, 32'h1);
        chk("popfull_ovf", {16'h0, overflow_cnt}, 32'd4);
        drain();
        chk("ovf_bcnt", {16'h0, byte_cnt}, 32'd25);
        chk("ovf_empty", {31'h0, fifo_empty}, 32'h1);

        // Flush with rx_valid while 5 queued and one byte in flight
        send(8'h20, 1'b1, 8'h20);
        for (int i = 1; i < 6; i++) begin
            send(8'hA0 + 8'(i), 1'b0, 8'h00);
        end
        chk("preflush_level", {27'h0, fifo_level}, 32'd5);
        flush    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        @(negedge clk);
        flush    = 1'b0;
        rx_valid = 1'b0;
        chk("flush_level", {27'h0, fifo_level}, 32'd0);
        chk("flush_empty", {31'h0, fifo_empty}, 32'h1);
        drain();
        repeat (20) @(negedge clk);
        chk("flush_ovf", {16'h0, overflow_cnt}, 32'd4);
        chk("flush_bcnt", {16'h0, byte_cnt}, 32'd26);
        chk("flush_starts", n_start, 32'd26);

        // Reset asserted during WAIT_BUSY
        mode = 2'b01;
        send(8'h6D, 1'b1, 8'h4D);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("arst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("arst_level", {27'h0, fifo_level}, 32'h0);
        chk("arst_empty", {31'h0, fifo_empty}, 32'h1);
        chk("arst_bcnt", {16'h0, byte_cnt}, 32'h0);
        chk("arst_ovf", {16'h0, overflow_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("arst_no_start", n_start, 32'd27);
        send(8'h61, 1'b1, 8'h41);
        drain();
        chk("post_rst_bcnt", {16'h0, byte_cnt}, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
